// File: rtl/match_sequencer_if.sv
// Handshake between the match sequencer and the screen-drawing engine.
// The sequencer is the master: it requests a screen and waits for done.
interface match_sequencer_if;
    logic       draw_req;
    logic [3:0] draw_sel;
    logic       draw_done;

    modport master (output draw_req, output draw_sel, input draw_done);
    modport slave  (input draw_req, input draw_sel, output draw_done);
endinterface

// File: rtl/match_sequencer.sv
// Rock-paper-scissors style match controller (cat/dog/chicken): latches both
// choices, scores rounds, and sequences title/scenario/winner screens.
module match_sequencer #(
    parameter int unsigned WIN_SCORE = 3
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              choose,
    input  logic              cont,
    input  logic              new_game,
    input  logic [2:0]        p1_choice,
    input  logic [2:0]        p2_choice,
    match_sequencer_if.master draw,
    output logic [3:0]        p1_score,
    output logic [3:0]        p2_score,
    output logic [1:0]        winner,
    output logic              busy
);

    localparam logic [3:0] WIN = 4'(WIN_SCORE);

    typedef enum logic [3:0] {
        IDLE, TITLE, WAIT_CHOOSE, RESOLVE, DRAW_SCEN,
        CHECK, WAIT_CONT, CLEAR, DRAW_WIN, OVER
    } state_t;

    function automatic logic [1:0] choice_idx(input logic [2:0] c);
        case (c)
            3'b010:  return 2'd1;
            3'b100:  return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

    // Index of the choice that beats idx: dog beats cat, chicken beats dog, cat beats chicken.
    function automatic logic [1:0] beater_of(input logic [1:0] idx);
        case (idx)
            2'd0:    return 2'd1;
            2'd1:    return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

    function automatic logic is_draw_state(input state_t s);
        return (s == TITLE) || (s == DRAW_SCEN) || (s == CLEAR) || (s == DRAW_WIN);
    endfunction

    state_t     state_reg, state_next;
    logic       choose_prev_reg, cont_prev_reg, new_game_prev_reg;
    logic       pending_reg, pending_next;
    logic [1:0] p1_idx_reg, p1_idx_next, p2_idx_reg, p2_idx_next;
    logic [3:0] p1_score_reg, p1_score_next, p2_score_reg, p2_score_next;
    logic [1:0] winner_reg, winner_next;
    logic       draw_req_reg, draw_req_next;
    logic [3:0] draw_sel_reg, draw_sel_next;
    logic       busy_reg, busy_next;

    logic       choose_edge, cont_edge, ng_edge, ng_any, in_draw, clear_game;
    logic       p1_wins, p2_wins;
    logic [3:0] scenario;

    assign choose_edge = choose & ~choose_prev_reg;
    assign cont_edge   = cont & ~cont_prev_reg;
    assign ng_edge     = new_game & ~new_game_prev_reg;
    assign ng_any      = ng_edge | pending_reg;
    assign in_draw     = is_draw_state(state_reg);
    // A new game restarts at once from a quiet state, but only after the transfer in a draw state.
    assign clear_game  = in_draw ? (draw.draw_done & ng_any) : ng_edge;
    assign p1_wins     = (p1_idx_reg == beater_of(p2_idx_reg));
    assign p2_wins     = (p2_idx_reg == beater_of(p1_idx_reg));
    assign scenario    = 4'd1 + 4'd3 * {2'b00, p2_idx_reg} + {2'b00, p1_idx_reg};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:        state_next = TITLE;
            TITLE:       if (draw.draw_done) state_next = ng_any ? IDLE : WAIT_CHOOSE;
            WAIT_CHOOSE: if (ng_edge) state_next = TITLE;
                         else if (choose_edge) state_next = RESOLVE;
            RESOLVE:     state_next = ng_edge ? TITLE : DRAW_SCEN;
            DRAW_SCEN:   if (draw.draw_done) state_next = ng_any ? IDLE : CHECK;
            CHECK:       if (ng_edge) state_next = TITLE;
                         else if (p1_score_reg == WIN || p2_score_reg == WIN) state_next = DRAW_WIN;
                         else state_next = WAIT_CONT;
            WAIT_CONT:   if (ng_edge) state_next = TITLE;
                         else if (cont_edge) state_next = CLEAR;
            CLEAR:       if (draw.draw_done) state_next = ng_any ? IDLE : WAIT_CHOOSE;
            DRAW_WIN:    if (draw.draw_done) state_next = ng_any ? IDLE : OVER;
            OVER:        if (ng_edge) state_next = TITLE;
            default:     state_next = IDLE;
        endcase
    end

    always_comb begin
        pending_next  = in_draw & ~draw.draw_done & ng_any;
        p1_idx_next   = p1_idx_reg;
        p2_idx_next   = p2_idx_reg;
        p1_score_next = p1_score_reg;
        p2_score_next = p2_score_reg;
        winner_next   = winner_reg;
        draw_sel_next = draw_sel_reg;
        draw_req_next = is_draw_state(state_next);
        busy_next     = !(state_next inside {WAIT_CHOOSE, WAIT_CONT, OVER});

        if (state_reg == WAIT_CHOOSE && state_next == RESOLVE) begin
            p1_idx_next = choice_idx(p1_choice);
            p2_idx_next = choice_idx(p2_choice);
        end

        if (clear_game) begin
            p1_score_next = 4'd0;
            p2_score_next = 4'd0;
            winner_next   = 2'b00;
        end else if (state_reg == RESOLVE) begin
            if (p1_wins && p1_score_reg != WIN) p1_score_next = p1_score_reg + 4'd1;
            if (p2_wins && p2_score_reg != WIN) p2_score_next = p2_score_reg + 4'd1;
        end else if (state_reg == CHECK && state_next == DRAW_WIN) begin
            winner_next = (p1_score_reg == WIN) ? 2'b01 : 2'b10;
        end

        // The screen id is chosen only on entry so it stays put for the whole transfer.
        if (state_next != state_reg) begin
            case (state_next)
                TITLE, CLEAR: draw_sel_next = 4'd0;
                DRAW_SCEN:    draw_sel_next = scenario;
                DRAW_WIN:     draw_sel_next = (p1_score_reg == WIN) ? 4'd10 : 4'd11;
                default:      draw_sel_next = draw_sel_reg;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            choose_prev_reg   <= 1'b1;
            cont_prev_reg     <= 1'b1;
            new_game_prev_reg <= 1'b1;
            pending_reg       <= 1'b0;
            p1_idx_reg        <= 2'd0;
            p2_idx_reg        <= 2'd0;
            p1_score_reg      <= 4'd0;
            p2_score_reg      <= 4'd0;
            winner_reg        <= 2'b00;
            draw_req_reg      <= 1'b0;
            draw_sel_reg      <= 4'd0;
            busy_reg          <= 1'b0;
        end else begin
            choose_prev_reg   <= choose;
            cont_prev_reg     <= cont;
            new_game_prev_reg <= new_game;
            pending_reg       <= pending_next;
            p1_idx_reg        <= p1_idx_next;
            p2_idx_reg        <= p2_idx_next;
            p1_score_reg      <= p1_score_next;
            p2_score_reg      <= p2_score_next;
            winner_reg        <= winner_next;
            draw_req_reg      <= draw_req_next;
            draw_sel_reg      <= draw_sel_next;
            busy_reg          <= busy_next;
        end
    end

    assign draw.draw_req = draw_req_reg;
    assign draw.draw_sel = draw_sel_reg;
    assign p1_score      = p1_score_reg;
    assign p2_score      = p2_score_reg;
    assign winner        = winner_reg;
    assign busy          = busy_reg;

endmodule

// File: tb/tb_match_sequencer.sv
// Directed plus randomized match scenarios checked against a round/score model
// derived from the game rules.
module tb_match_sequencer;
    localparam int WIN = 3;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       choose = 1'b0;
    logic       cont = 1'b0;
    logic       new_game = 1'b0;
    logic [2:0] p1_choice = 3'b000;
    logic [2:0] p2_choice = 3'b000;
    logic [3:0] p1_score, p2_score;
    logic [1:0] winner;
    logic       busy;

    match_sequencer_if dif();

    match_sequencer #(.WIN_SCORE(WIN)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .choose    (choose),
        .cont      (cont),
        .new_game  (new_game),
        .p1_choice (p1_choice),
        .p2_choice (p2_choice),
        .draw      (dif),
        .p1_score  (p1_score),
        .p2_score  (p2_score),
        .winner    (winner),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int m_p1 = 0;
    int m_p2 = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int idx_of(input logic [2:0] c);
        if (c == 3'b010) return 1;
        if (c == 3'b100) return 2;
        return 0;
    endfunction

    // 0 cat, 1 dog, 2 chicken
    function automatic bit beats(input int a, input int b);
        return (a == 1 && b == 0) || (a == 0 && b == 2) || (a == 2 && b == 1);
    endfunction

    task automatic serve_draw(input string tag, input int sel, input int lat);
        check({tag, "_req"}, 32'(dif.draw_req), 1);
        check({tag, "_sel"}, 32'(dif.draw_sel), sel);
        for (int i = 1; i < lat; i++) begin
            tick();
            check({tag, "_hold"}, 32'(dif.draw_sel), sel);
        end
        dif.draw_done = 1'b1;
        tick();
        dif.draw_done = 1'b0;
        check({tag, "_req_drop"}, 32'(dif.draw_req), 0);
    endtask

    task automatic play_round(input logic [2:0] p1c, input logic [2:0] p2c);
        int a, b, scen;
        a = idx_of(p1c);
        b = idx_of(p2c);
        scen = 1 + 3 * b + a;
        if (beats(a, b)) m_p1++;
        else if (beats(b, a)) m_p2++;
        p1_choice = p1c;
        p2_choice = p2c;
        choose = 1'b1;
        tick();
        choose = 1'b0;
        p1_choice = 3'($urandom_range(0, 7));
        p2_choice = 3'($urandom_range(0, 7));
        check("resolve_busy", 32'(busy), 1);
        check("resolve_noreq", 32'(dif.draw_req), 0);
        tick();
        check("p1_score", 32'(p1_score), m_p1);
        check("p2_score", 32'(p2_score), m_p2);
        $display("round p1=%b p2=%b scen=%0d score %0d-%0d", p1c, p2c, scen, m_p1, m_p2);
        serve_draw("scen", scen, int'($urandom_range(1, 4)));
        tick();
        if (m_p1 == WIN || m_p2 == WIN) begin
            check("win_req", 32'(dif.draw_req), 1);
            check("win_sel", 32'(dif.draw_sel), (m_p1 == WIN) ? 10 : 11);
            check("winner", 32'(winner), (m_p1 == WIN) ? 1 : 2);
        end else begin
            check("wait_cont_busy", 32'(busy), 0);
            check("wait_cont_req", 32'(dif.draw_req), 0);
        end
    endtask

    task automatic do_cont();
        dif.draw_done = 1'b1;
        tick();
        dif.draw_done = 1'b0;
        check("stray_done_busy", 32'(busy), 0);
        cont = 1'b1;
        tick();
        cont = 1'b0;
        serve_draw("clear", 0, int'($urandom_range(1, 3)));
        check("wait_choose_busy", 32'(busy), 0);
    endtask

    task automatic finish_game();
        serve_draw("winscr", (m_p1 == WIN) ? 10 : 11, 2);
        check("over_busy", 32'(busy), 0);
    endtask

    task automatic start_new_game();
        new_game = 1'b1;
        tick();
        new_game = 1'b0;
        m_p1 = 0;
        m_p2 = 0;
        check("ng_p1", 32'(p1_score), 0);
        check("ng_p2", 32'(p2_score), 0);
        check("ng_winner", 32'(winner), 0);
        serve_draw("title", 0, 3);
        check("ng_busy", 32'(busy), 0);
    endtask

    initial begin
        dif.draw_done = 1'b0;
        // Reset state
        tick();
        check("rst_req", 32'(dif.draw_req), 0);
        check("rst_sel", 32'(dif.draw_sel), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_winner", 32'(winner), 0);
        resetn = 1'b1;
        tick();
        serve_draw("title", 0, 3);
        check("start_busy", 32'(busy), 0);
        check("start_p1", 32'(p1_score), 0);
        check("start_p2", 32'(p2_score), 0);

        // Directed rounds: dog vs cat, chicken tie, invalid(cat) vs dog
        play_round(3'b010, 3'b001);
        do_cont();
        play_round(3'b100, 3'b100);
        do_cont();
        play_round(3'b011, 3'b010);
        do_cont();

        // Randomized games played to completion
        for (int g = 0; g < 3; g++) begin
            int rounds;
            rounds = 0;
            while (m_p1 != WIN && m_p2 != WIN && rounds < 60) begin
                play_round(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
                if (m_p1 != WIN && m_p2 != WIN) do_cont();
                rounds++;
            end
            check("game_ended", 32'(m_p1 == WIN || m_p2 == WIN), 1);
            if (m_p1 == WIN || m_p2 == WIN) finish_game();
            start_new_game();
        end

        // new_game during a scenario draw that stalls for 10 cycles
        p1_choice = 3'b010;
        p2_choice = 3'b100;
        choose = 1'b1;
        tick();
        choose = 1'b0;
        tick();
        check("pend_sel", 32'(dif.draw_sel), 8);
        check("pend_p2", 32'(p2_score), 1);
        new_game = 1'b1;
        tick();
        new_game = 1'b0;
        for (int i = 0; i < 10; i++) begin
            check("pend_req_hold", 32'(dif.draw_req), 1);
            check("pend_sel_hold", 32'(dif.draw_sel), 8);
            tick();
        end
        dif.draw_done = 1'b1;
        tick();
        dif.draw_done = 1'b0;
        m_p1 = 0;
        m_p2 = 0;
        check("pend_req_drop", 32'(dif.draw_req), 0);
        check("pend_p1_clr", 32'(p1_score), 0);
        check("pend_p2_clr", 32'(p2_score), 0);
        tick();
        serve_draw("pend_title", 0, 2);

        // Three chicken-vs-cat rounds: player 2 takes the match
        play_round(3'b100, 3'b001);
        do_cont();
        play_round(3'b100, 3'b001);
        do_cont();
        play_round(3'b100, 3'b001);
        finish_game();
        choose = 1'b1;
        tick();
        choose = 1'b0;
        tick();
        tick();
        check("over_ignore_req", 32'(dif.draw_req), 0);
        check("over_ignore_busy", 32'(busy), 0);
        check("over_p2", 32'(p2_score), 3);
        check("over_winner", 32'(winner), 2);
        start_new_game();

        // Asynchronous reset in the middle of the winner screen
        play_round(3'b010, 3'b001);
        do_cont();
        play_round(3'b010, 3'b001);
        do_cont();
        play_round(3'b010, 3'b001);
        #2;
        resetn = 1'b0;
        choose = 1'b1;
        #1;
        check("async_req", 32'(dif.draw_req), 0);
        check("async_p1", 32'(p1_score), 0);
        check("async_winner", 32'(winner), 0);
        check("async_sel", 32'(dif.draw_sel), 0);
        tick();
        tick();
        resetn = 1'b1;
        m_p1 = 0;
        m_p2 = 0;
        tick();
        serve_draw("rst_title", 0, 2);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("held_choose_busy", 32'(busy), 0);
            check("held_choose_req", 32'(dif.draw_req), 0);
        end
        choose = 1'b0;
        tick();
        play_round(3'b100, 3'b010);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not reach summary");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/match_sequencer.md
MATCH_SEQUENCER -- requirements
Module: match_sequencer

Interface
REQ-001 The block SHALL have one parameter: WIN_SCORE, 3, points that end a match (1..15).
REQ-002 The block SHALL have these ports:
- clk  in  1  system clock, CLOCK_50 domain, rising edge
- resetn  in  1  asynchronous, active-low reset
- choose  in  1  level, high while the choose button is held
- cont  in  1  level, high while the continue button is held
- new_game  in  1  level, high while the new-game button is held
- p1_choice  in  3  one-hot: 001 cat, 010 dog, 100 chicken
- p2_choice  in  3  same encoding as p1_choice
- draw_done  in  1  screen-drawing engine finished the current screen
- draw_req  out  1  request to draw the screen given by draw_sel
- draw_sel  out  4  screen ID: 0 title/clear, 1..9 scenario, 10 P1 wins, 11 P2 wins
- p1_score  out  4  player 1 points
- p2_score  out  4  player 2 points
- winner  out  2  00 none, 01 P1, 10 P2
- busy  out  1  high in any state other than WAIT_CHOOSE, WAIT_CONT or OVER

Function
REQ-003 choose, cont and new_game SHALL each be rising-edge detected against a registered previous value; an edge is a clock edge where the input is sampled 1 and the previous value is 0.
REQ-004 A non-one-hot choice SHALL be treated as cat.
REQ-005 Choices SHALL map to indices cat=0, dog=1, chicken=2.
REQ-006 The scenario ID SHALL be 1 + 3*p2idx + p1idx.
REQ-007 Round rules SHALL be: dog beats cat; cat beats chicken; chicken beats dog; equal choices are a tie and award no point.
REQ-008 The state machine SHALL have these states and transitions:
- IDLE -> TITLE unconditionally.
- TITLE (draw, sel 0) -> WAIT_CHOOSE on draw_done.
- WAIT_CHOOSE -> RESOLVE on a choose edge; both choices are latched on that edge.
- RESOLVE (1 cycle): increment the winner's score -> DRAW_SCEN.
- DRAW_SCEN (draw, sel = scenario) -> CHECK on draw_done.
- CHECK (1 cycle) -> DRAW_WIN if a score equals WIN_SCORE, else WAIT_CONT.
- WAIT_CONT -> CLEAR on a cont edge.
- CLEAR (draw, sel 0) -> WAIT_CHOOSE on draw_done.
- DRAW_WIN (draw, sel 10 or 11) -> OVER on draw_done.
- OVER -> TITLE on a new_game edge; scores and winner clear to 0 on that same edge.
REQ-009 Draw handshake:
- draw_req is a registered output, high exactly in the draw states (TITLE, DRAW_SCEN, CLEAR, DRAW_WIN).
- draw_sel holds stable while draw_req is high.
- A transfer completes in the cycle where draw_req and draw_done are both high; draw_req is low in the following cycle.
- draw_req is low for at least 1 cycle between transfers.
- draw_done while draw_req is low is ignored.
REQ-010 Latency: for a choose edge at clock edge k, state is RESOLVE after edge k; after edge k+1 scores are updated, draw_req=1 and draw_sel=scenario.
REQ-011 Scores SHALL never exceed WIN_SCORE.
REQ-012 winner SHALL be set on entry to DRAW_WIN and hold until new_game or reset.
REQ-013 A new_game edge outside OVER SHALL be handled as follows:
- In a non-draw state: scores and winner clear and the block goes to TITLE on the next edge.
- In a draw state: the event is stored in a pending flag, the transfer completes, then the block clears and goes to TITLE.
- new_game takes priority over choose and cont on the same edge.
REQ-014 choose and cont edges SHALL be ignored (not queued) in states that do not consume them.

Reset
REQ-015 While resetn=0, the block SHALL hold:
- state=IDLE
- draw_req=0, draw_sel=0, p1_score=0, p2_score=0, winner=00, busy=0
- pending flag=0
- edge-detect previous registers=1, so a button held through reset produces no edge.
REQ-016 Reset asserted mid-transfer SHALL force all outputs to their reset values immediately, without waiting for the clock.

Verification
REQ-017 Release resetn with draw_done returned 3 cycles after draw_req -> draw_req=1 and draw_sel=0 one cycle after IDLE; draw_req=0 after done; busy=0 in WAIT_CHOOSE; scores 0/0.
REQ-018 p1=010, p2=001, choose pulse -> draw_sel=2, p1_score=1, p2_score=0, draw_req high 2 edges after the choose edge.
REQ-019 p1=100, p2=100 -> draw_sel=9, scores unchanged. p1=011, p2=010 -> draw_sel=4, p2_score +1.
REQ-020 Three rounds with p1=100, p2=001 (cont between rounds) -> p2_score=3, draw_sel=11, winner=10. A further choose is ignored. A new_game edge -> scores 0/0, winner=00, draw_sel=0.
REQ-021 new_game edge during DRAW_SCEN with draw_done held low for 10 cycles -> draw_req stays 1 and draw_sel stays stable; after done, next transfer sel=0 and scores 0/0.
REQ-022 resetn=0 mid-DRAW_WIN -> draw_req, scores and winner are 0 asynchronously. Holding choose=1 through reset release -> no round until choose is released and pressed again.
